// File: rtl/ins_prefetch_queue.sv
// ins_prefetch_queue
//   Fetch stage in front of the instruction splitter. It owns the fetch PC and
//   issues InsROM read requests. Returned words go into a small FIFO. Complete
//   one- or two-word instructions are offered to decode over a valid/ready
//   handshake. A redirect flushes everything and restarts fetch at a new PC.
//
//   Optional feature: define PREFETCH_PERF_EN to add the perf_starve port. It is
//   a saturating count of cycles in which decode was ready but no instruction
//   was available.
//
// Ports
//   clk, rst     rising-edge clock; asynchronous active-high reset
//   en           fetch enable; new ROM requests are issued only when high
//   rom_req      ROM read request; rom_addr is the read address
//   rom_data     ROM read data, one cycle after rom_req
//   redir        redirect/flush strobe; redir_addr is the new fetch PC
//   ins_valid    complete instruction at the queue head; ins_ready accepts it
//   ins_word     first word; ins_ext holds the second word (0 if one-word)
//   ins_two      two-word instruction flag; ins_pc is the ROM address of ins_word
//   q_count      words currently held in the FIFO
//   perf_starve  (PREFETCH_PERF_EN only) starvation cycle counter
module ins_prefetch_queue #(
  parameter int             DW       = 16,
  parameter int             AW       = 16,
  parameter int             DEPTH    = 4,
  parameter logic [AW-1:0]  RESET_PC = {AW{1'b0}}
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  output logic                      rom_req,
  output logic [AW-1:0]             rom_addr,
  input  logic [DW-1:0]             rom_data,
  input  logic                      redir,
  input  logic [AW-1:0]             redir_addr,
  output logic                      ins_valid,
  input  logic                      ins_ready,
  output logic [DW-1:0]             ins_word,
  output logic [DW-1:0]             ins_ext,
  output logic                      ins_two,
  output logic [AW-1:0]             ins_pc,
  output logic [$clog2(DEPTH):0]    q_count
`ifdef PREFETCH_PERF_EN
  ,
  output logic [15:0]               perf_starve
`endif
);

  localparam int              PW        = $clog2(DEPTH);
  localparam int              CW        = PW + 1;
  localparam logic [CW:0]     DEPTH_OCC = (CW+1)'(DEPTH);
  localparam logic [CW-1:0]   ONE_W     = CW'(1);
  localparam logic [CW-1:0]   TWO_W     = CW'(2);

  // Mode field 01 (immediate) or 10 (direct) carries a second word.
  function automatic logic is_two_word(input logic [DW-1:0] w);
    return (w[DW-1 -: 2] == 2'b01) || (w[DW-1 -: 2] == 2'b10);
  endfunction

  logic [DW-1:0] mem_data_r [DEPTH];
  logic [AW-1:0] mem_addr_r [DEPTH];
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] wr_ptr_r;
  logic [CW-1:0] count_r;
  logic [AW-1:0] fetch_pc_r;
  logic [AW-1:0] inflight_addr_r;
  logic          inflight_r;

  logic [PW-1:0] next_ptr_s;
  logic [DW-1:0] head_word_s;
  logic          head_two_s;
  logic          head_avail_s;
  logic          valid_s;
  logic          push_s;
  logic          issue_s;
  logic [1:0]    pop_cnt_s;
  logic [CW:0]   occ_s;

  // Head decode, handshake and issue decision.
  always_comb begin
    next_ptr_s   = rd_ptr_r + PW'(1);
    head_word_s  = mem_data_r[rd_ptr_r];
    head_two_s   = is_two_word(head_word_s);
    if (head_two_s) begin
      head_avail_s = (count_r >= TWO_W);
    end else begin
      head_avail_s = (count_r >= ONE_W);
    end
    // Redirect suppresses the handshake so a stale instruction never pops.
    valid_s      = head_avail_s & ~redir & ~rst;
    if (valid_s & ins_ready) begin
      pop_cnt_s = head_two_s ? 2'd2 : 2'd1;
    end else begin
      pop_cnt_s = 2'd0;
    end
    // A return is only useful if no redirect arrives in the cycle it lands.
    push_s       = inflight_r & ~redir;
    // Reserve a slot for the word still in flight so the FIFO cannot overflow.
    occ_s        = {1'b0, count_r} + {{CW{1'b0}}, inflight_r};
    issue_s      = en & ~redir & ~rst & (occ_s < DEPTH_OCC);
  end

  // Output mapping; instruction fields come straight from the head entries.
  always_comb begin
    rom_req   = issue_s;
    rom_addr  = fetch_pc_r;
    ins_valid = valid_s;
    ins_word  = head_word_s;
    ins_two   = head_two_s;
    ins_pc    = mem_addr_r[rd_ptr_r];
    q_count   = count_r;
    if (head_two_s) begin
      ins_ext = mem_data_r[next_ptr_s];
    end else begin
      ins_ext = {DW{1'b0}};
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_data_r[i] <= {DW{1'b0}};
        mem_addr_r[i] <= {AW{1'b0}};
      end
    end else if (push_s) begin
      mem_data_r[wr_ptr_r] <= rom_data;
      mem_addr_r[wr_ptr_r] <= inflight_addr_r;
    end
  end

  // Fetch PC, in-flight tracking, FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_r      <= RESET_PC;
      inflight_r      <= 1'b0;
      inflight_addr_r <= {AW{1'b0}};
      rd_ptr_r        <= {PW{1'b0}};
      wr_ptr_r        <= {PW{1'b0}};
      count_r         <= {CW{1'b0}};
    end else if (redir) begin
      fetch_pc_r      <= redir_addr;
      inflight_r      <= 1'b0;
      rd_ptr_r        <= {PW{1'b0}};
      wr_ptr_r        <= {PW{1'b0}};
      count_r         <= {CW{1'b0}};
    end else begin
      inflight_r      <= issue_s;
      if (issue_s) begin
        inflight_addr_r <= fetch_pc_r;
        fetch_pc_r      <= fetch_pc_r + AW'(1);
      end
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      rd_ptr_r <= rd_ptr_r + PW'(pop_cnt_s);
      count_r  <= count_r + CW'(push_s) - CW'(pop_cnt_s);
    end
  end

`ifdef PREFETCH_PERF_EN
  // Saturating count of cycles in which decode waited on an empty head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_starve <= 16'h0000;
    end else if (ins_ready & ~valid_s & (perf_starve != 16'hFFFF)) begin
      perf_starve <= perf_starve + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_ins_prefetch_queue.sv
module tb_ins_prefetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        rom_req;
  logic [15:0] rom_addr;
  logic [15:0] rom_data = 16'h0000;
  logic        redir = 1'b0;
  logic [15:0] redir_addr = 16'h0000;
  logic        ins_valid;
  logic        ins_ready = 1'b0;
  logic [15:0] ins_word, ins_ext, ins_pc;
  logic        ins_two;
  logic [2:0]  q_count;
`ifdef PREFETCH_PERF_EN
  logic [15:0] perf_starve;
`endif

  ins_prefetch_queue dut (
    .clk(clk), .rst(rst), .en(en),
    .rom_req(rom_req), .rom_addr(rom_addr), .rom_data(rom_data),
    .redir(redir), .redir_addr(redir_addr),
    .ins_valid(ins_valid), .ins_ready(ins_ready),
    .ins_word(ins_word), .ins_ext(ins_ext), .ins_two(ins_two),
    .ins_pc(ins_pc), .q_count(q_count)
`ifdef PREFETCH_PERF_EN
    , .perf_starve(perf_starve)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ROM contents: explicit overrides, otherwise a fixed scramble of the address.
  logic [15:0] rom [logic [15:0]];
  function automatic logic [15:0] rom_read(input logic [15:0] a);
    if (rom.exists(a)) return rom[a];
    return (a * 16'h9E37) ^ {a[4:0], a[15:5]} ^ 16'h1234;
  endfunction

  // ROM responder: data is valid the cycle after a request.
  always @(posedge clk) begin
    if (rom_req) rom_data <= rom_read(rom_addr);
    else         rom_data <= 16'($urandom);
  end

  function automatic logic mode_two(input logic [15:0] w);
    return (w[15:14] == 2'b01) || (w[15:14] == 2'b10);
  endfunction

  typedef struct { logic [15:0] d; logic [15:0] a; } ent_t;
  typedef struct { logic [15:0] word; logic [15:0] ext; logic [15:0] pc; logic two; } acc_t;

  ent_t        m_q[$];
  logic        m_inflight = 1'b0;
  logic [15:0] m_iaddr = 16'h0000;
  logic [15:0] m_pc = 16'h0000;
  logic [15:0] m_starve = 16'h0000;
  acc_t        acc_log[$];
  logic [15:0] req_log[$];

  // Reference model and per-cycle comparison, evaluated mid-cycle.
  always @(negedge clk) begin
    logic exp_req, exp_valid, h_two;
    int   need;
    if (rst) begin
      m_q.delete(); m_inflight = 1'b0; m_pc = 16'h0000; m_starve = 16'h0000;
    end
    h_two     = (m_q.size() > 0) && mode_two(m_q[0].d);
    need      = h_two ? 2 : 1;
    exp_req   = !rst && en && !redir && ((m_q.size() + int'(m_inflight)) < DEPTH);
    exp_valid = !rst && !redir && (m_q.size() >= need);
    check("rom_req", {31'd0, rom_req}, {31'd0, exp_req});
    check("rom_addr", {16'd0, rom_addr}, {16'd0, m_pc});
    check("q_count", {29'd0, q_count}, 32'(m_q.size()));
    check("ins_valid", {31'd0, ins_valid}, {31'd0, exp_valid});
    if (exp_valid && ins_valid) begin
      check("ins_word", {16'd0, ins_word}, {16'd0, m_q[0].d});
      check("ins_pc", {16'd0, ins_pc}, {16'd0, m_q[0].a});
      check("ins_two", {31'd0, ins_two}, {31'd0, h_two});
      check("ins_ext", {16'd0, ins_ext}, {16'd0, (h_two ? m_q[1].d : 16'h0000)});
    end
`ifdef PREFETCH_PERF_EN
    check("perf_starve", {16'd0, perf_starve}, {16'd0, m_starve});
`endif
    if (rom_req) req_log.push_back(rom_addr);
    if (ins_valid && ins_ready)
      acc_log.push_back('{word: ins_word, ext: ins_ext, pc: ins_pc, two: ins_two});
    // Advance the model to the state after the coming rising edge.
    if (!rst) begin
      if (ins_ready && !exp_valid && m_starve != 16'hFFFF) m_starve = m_starve + 16'h0001;
      if (redir) begin
        m_q.delete(); m_inflight = 1'b0; m_pc = redir_addr;
      end else begin
        if (exp_valid && ins_ready) begin
          void'(m_q.pop_front());
          if (h_two) void'(m_q.pop_front());
        end
        if (m_inflight) m_q.push_back('{d: rom_read(m_iaddr), a: m_iaddr});
        m_inflight = exp_req;
        if (exp_req) begin m_iaddr = m_pc; m_pc = m_pc + 16'h0001; end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_acc(input int target, input string name);
    int k = 0;
    while (acc_log.size() < target && k < 200) begin step(); k++; end
    check(name, 32'(acc_log.size() >= target), 32'd1);
  endtask

  initial begin
    int mark;
    logic [15:0] held_word, held_pc;
    rom[16'h0000] = 16'h0123; rom[16'h0001] = 16'h0456;
    rom[16'h0002] = 16'h3789; rom[16'h0003] = 16'hC000;
    rom[16'hFFFF] = 16'h1111;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rom_req", {31'd0, rom_req}, 32'd0);
    check("rst_ins_valid", {31'd0, ins_valid}, 32'd0);
    check("rst_q_count", {29'd0, q_count}, 32'd0);
    check("rst_rom_addr", {16'd0, rom_addr}, 32'd0);

    // Reset release with a one-word stream.
    step(); rst = 1'b0; en = 1'b1; ins_ready = 1'b1;
    wait_acc(4, "t2_timeout");
    if (req_log.size() >= 3) begin
      check("t1_addr0", {16'd0, req_log[0]}, 32'h0000);
      check("t1_addr1", {16'd0, req_log[1]}, 32'h0001);
      check("t1_addr2", {16'd0, req_log[2]}, 32'h0002);
    end
    if (acc_log.size() >= 4) begin
      check("t2_pc0", {16'd0, acc_log[0].pc}, 32'h0000);
      check("t2_pc1", {16'd0, acc_log[1].pc}, 32'h0001);
      check("t2_pc2", {16'd0, acc_log[2].pc}, 32'h0002);
      check("t2_pc3", {16'd0, acc_log[3].pc}, 32'h0003);
      check("t2_word2", {16'd0, acc_log[2].word}, 32'h3789);
      check("t2_word3", {16'd0, acc_log[3].word}, 32'hC000);
      check("t2_two3", {31'd0, acc_log[3].two}, 32'd0);
      check("t2_ext3", {16'd0, acc_log[3].ext}, 32'h0000);
    end

    // Two-word instruction at address 0.
    redir = 1'b1; redir_addr = 16'h0000;
    rom[16'h0000] = 16'h4A00; rom[16'h0001] = 16'hBEEF;
    mark = acc_log.size();
    step(); redir = 1'b0;
    wait_acc(mark + 2, "t3_timeout");
    if (acc_log.size() >= mark + 2) begin
      check("t3_word", {16'd0, acc_log[mark].word}, 32'h4A00);
      check("t3_ext", {16'd0, acc_log[mark].ext}, 32'hBEEF);
      check("t3_two", {31'd0, acc_log[mark].two}, 32'd1);
      check("t3_pc", {16'd0, acc_log[mark].pc}, 32'h0000);
      check("t3_next_pc", {16'd0, acc_log[mark+1].pc}, 32'h0002);
    end

    // Backpressure until full, then a single-cycle pop.
    ins_ready = 1'b0;
    repeat (10) step();
    @(negedge clk);
    check("t4_full", {29'd0, q_count}, 32'd4);
    check("t4_no_req", {31'd0, rom_req}, 32'd0);
    held_word = ins_word; held_pc = ins_pc;
    repeat (3) step();
    @(negedge clk);
    check("t4_hold_word", {16'd0, ins_word}, {16'd0, held_word});
    check("t4_hold_pc", {16'd0, ins_pc}, {16'd0, held_pc});
    check("t4_hold_valid", {31'd0, ins_valid}, 32'd1);
    step(); ins_ready = 1'b1;
    step(); ins_ready = 1'b0;
    @(negedge clk);
    check("t4_req_after_pop", {31'd0, rom_req}, 32'd1);

    // Redirect while that request is in flight.
    step(); redir = 1'b1; redir_addr = 16'h0100;
    @(negedge clk);
    check("t5_req_in_redir", {31'd0, rom_req}, 32'd0);
    check("t5_valid_in_redir", {31'd0, ins_valid}, 32'd0);
    step(); redir = 1'b0;
    @(negedge clk);
    check("t5_q_count", {29'd0, q_count}, 32'd0);
    check("t5_req", {31'd0, rom_req}, 32'd1);
    check("t5_addr", {16'd0, rom_addr}, 32'h0100);
    step(); ins_ready = 1'b1;
    mark = acc_log.size();
    wait_acc(mark + 1, "t5_timeout");
    if (acc_log.size() > mark) check("t5_first_pc", {16'd0, acc_log[mark].pc}, 32'h0100);

    // Address wrap.
    redir = 1'b1; redir_addr = 16'hFFFF;
    mark = acc_log.size();
    step(); redir = 1'b0;
    @(negedge clk);
    check("t6_addr_ffff", {16'd0, rom_addr}, 32'hFFFF);
    check("t6_req0", {31'd0, rom_req}, 32'd1);
    step();
    @(negedge clk);
    check("t6_addr_0000", {16'd0, rom_addr}, 32'h0000);
    wait_acc(mark + 2, "t6_timeout");
    if (acc_log.size() >= mark + 2) begin
      check("t6_pc0", {16'd0, acc_log[mark].pc}, 32'hFFFF);
      check("t6_word0", {16'd0, acc_log[mark].word}, 32'h1111);
      check("t6_pc1", {16'd0, acc_log[mark+1].pc}, 32'h0000);
      check("t6_ext1", {16'd0, acc_log[mark+1].ext}, 32'hBEEF);
    end

    // Randomized traffic against the model, with one mid-run reset.
    for (int c = 0; c < 3000; c++) begin
      step();
      en        = ($urandom_range(0, 9) != 0);
      ins_ready = ($urandom_range(0, 2) != 0);
      redir     = ($urandom_range(0, 29) == 0);
      redir_addr = ($urandom_range(0, 4) == 0) ? 16'(16'hFFFC + 16'($urandom_range(0, 3)))
                                                : 16'($urandom);
      rst       = (c == 1500);
    end
    step(); rst = 1'b0; redir = 1'b0;
    repeat (5) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
